// File: rtl/gpio_input_cond_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpio_input_cond_pkg: shared widths, bit positions and helpers for  |
// | the GPIO input conditioner.                  Revision: 1.0         |
// +--------------------------------------------------------------------+
package gpio_input_cond_pkg;

  localparam int GPIO_W  = 32;
  localparam int KEY_W   = 4;
  localparam int SW_W    = 10;
  localparam int KEY_LSB = 0;
  localparam int SW_LSB  = 4;

  // Bits needed to hold 0..count-1, never less than one bit.
  function automatic int cnt_width(input int count);
    return (count > 2) ? $clog2(count) : 1;
  endfunction

endpackage : gpio_input_cond_pkg
`default_nettype wire

// File: rtl/gpio_input_conditioner_debounce_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_bit: 2-flop synchronizer plus tick-qualified debouncer    |
// | for one input. Edge regs only with GPIO_INPUT_COND_EDGE_EN.        |
// |                                              Revision: 1.0         |
// +--------------------------------------------------------------------+
module debounce_bit
  import gpio_input_cond_pkg::*;
#(
  parameter int   STABLE_TICKS = 8,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync != db) && tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_BIT;
      sync <= RESET_BIT;
      cnt  <= '0;
      db   <= RESET_BIT;
    end else begin
      meta <= raw;
      sync <= meta;
      // Any cycle agreeing with db restarts qualification.
      if (sync == db) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          db  <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef GPIO_INPUT_COND_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & sync;
      fall <= accept & ~sync;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule : debounce_bit
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpio_input_conditioner: synchronize, debounce and pack raw KEY/SW  |
// | inputs into the 32-bit PIO word. Macro: GPIO_INPUT_COND_EDGE_EN.   |
// |                                              Revision: 1.0         |
// +--------------------------------------------------------------------+
module gpio_input_conditioner
  import gpio_input_cond_pkg::*;
#(
  parameter int                NUM_IN       = 14,
  parameter int                CLK_HZ       = 50_000_000,
  parameter int                TICK_HZ      = 1000,
  parameter int                STABLE_TICKS = 8,
  parameter logic [NUM_IN-1:0] RESET_VAL    = NUM_IN'({{SW_W{1'b0}}, {KEY_W{1'b1}}})
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] raw_i,
  output logic [GPIO_W-1:0] gpio_in_o,
  output logic              tick_o,
  output logic [NUM_IN-1:0] rise_o,
  output logic [NUM_IN-1:0] fall_o
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = cnt_width(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [NUM_IN-1:0] db;

  // With DIV == 1 the counter sits at 0 == PRE_LAST, so tick is constant high.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick   = (pre_cnt == PRE_LAST);
  assign tick_o = tick;

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
      debounce_bit #(
        .STABLE_TICKS (STABLE_TICKS),
        .RESET_BIT    (RESET_VAL[i])
      ) u_debounce_bit (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_i[i]),
        .tick  (tick),
        .db    (db[i]),
        .rise  (rise_o[i]),
        .fall  (fall_o[i])
      );
    end
  endgenerate

  assign gpio_in_o = GPIO_W'(db);

endmodule : gpio_input_conditioner
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// Bench for gpio_input_conditioner: directed scenarios plus a per-cycle
// comparison against an arithmetic tick-window model.
module tb_gpio_input_conditioner;

  localparam int NI  = 14;
  localparam int DIV = 10;
  localparam int ST  = 4;
  localparam logic [NI-1:0] RV = 14'h000F;
`ifdef GPIO_INPUT_COND_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] raw_i = 14'h3FF0;
  logic [31:0]   gpio_in_o;
  logic          tick_o;
  logic [NI-1:0] rise_o, fall_o;

  gpio_input_conditioner #(
    .NUM_IN(NI), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(ST), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .raw_i(raw_i), .gpio_in_o(gpio_in_o),
    .tick_o(tick_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: sync is raw delayed two cycles; a bit is accepted on the cycle
  // where ST ticks have elapsed since sync last agreed with the debounced value.
  // Ticks occur in post-reset cycles n with n % DIV == DIV-1.
  logic [NI-1:0] m_s1, m_s2, m_db, m_rise, m_fall, nd;
  logic          m_tick;
  int            n;
  int            last_eq [NI];
  bit            started = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_s1 = RV; m_s2 = RV; m_db = RV; m_rise = '0; m_fall = '0;
      n = 0; m_tick = 1'b0;
      for (int i = 0; i < NI; i++) last_eq[i] = -1;
      started = 1'b1;
    end else begin
      nd = m_db;
      for (int i = 0; i < NI; i++) begin
        if (m_s2[i] == m_db[i]) last_eq[i] = n;
        else if ((n + 1) / DIV - (last_eq[i] + 1) / DIV >= ST) begin
          nd[i] = m_s2[i];
          last_eq[i] = n;
        end
      end
      m_rise = nd & ~m_db;
      m_fall = ~nd & m_db;
      m_db = nd; m_s2 = m_s1; m_s1 = raw_i;
      n++;
      m_tick = (n % DIV == DIV - 1);
    end
  end

  // Per-cycle compare plus event counters for the directed scenarios.
  int            rise_cnt [NI];
  int            fall_cnt [NI];
  int            chg_cnt  [NI];
  logic [NI-1:0] prev_db;
  bit            prev_ok = 1'b0;

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("gpio_model", gpio_in_o, {18'b0, m_db});
      check("tick_model", {31'b0, tick_o}, {31'b0, m_tick});
      check("rise_model", {18'b0, rise_o}, {18'b0, m_rise & {NI{EDGE}}});
      check("fall_model", {18'b0, fall_o}, {18'b0, m_fall & {NI{EDGE}}});
      for (int i = 0; i < NI; i++) begin
        if (rise_o[i]) rise_cnt[i]++;
        if (fall_o[i]) fall_cnt[i]++;
        if (prev_ok && gpio_in_o[i] != prev_db[i]) chg_cnt[i]++;
      end
      prev_db = gpio_in_o[NI-1:0];
      prev_ok = 1'b1;
    end
  end

  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NI; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; chg_cnt[i] = 0;
    end
  endtask

  task automatic wait_bit(input int b, input logic v, input int maxc, output int c);
    c = 0;
    while (gpio_in_o[b] !== v && c < maxc) begin
      @(posedge clk); #1; c++;
    end
  endtask

  int lat;
  int rsum;

  initial begin
    for (int i = 0; i < NI; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; chg_cnt[i] = 0;
    end
    // 1. Reset with SWs high and KEYs low on the pins.
    step(3);
    check("reset_gpio", gpio_in_o, 32'h0000000F);
    check("reset_rise", {18'b0, rise_o}, 32'h0);
    check("reset_fall", {18'b0, fall_o}, 32'h0);
    reset = 1'b0;
    step(20);
    check("post_reset_gpio", gpio_in_o, 32'h0000000F);
    step(30);
    check("all_bits_accepted", gpio_in_o, 32'h00003FF0);
    raw_i = RV;
    step(50);
    check("back_to_idle", gpio_in_o, 32'h0000000F);

    // 2. Clean press of KEY0.
    clear_counts();
    raw_i[0] = 1'b0;
    wait_bit(0, 1'b0, 60, lat);
    check("press_latency_ok", {31'b0, (lat >= 33 && lat <= 43)}, 32'h1);
    check("press_fall_now", {31'b0, fall_o[0]}, {31'b0, EDGE});
    step(1);
    check("press_fall_gone", {31'b0, fall_o[0]}, 32'h0);
    step(5);
    check("press_fall_count", fall_cnt[0], EDGE ? 32'd1 : 32'd0);
    check("press_gpio", gpio_in_o, 32'h0000000E);

    // 3. Bouncing SW0 settling high.
    clear_counts();
    raw_i[4] = 1'b1; step(7);
    raw_i[4] = 1'b0; step(7);
    raw_i[4] = 1'b1; step(7);
    raw_i[4] = 1'b0; step(7);
    raw_i[4] = 1'b1;
    wait_bit(4, 1'b1, 60, lat);
    check("bounce_latency_ok", {31'b0, (lat >= 33 && lat <= 43)}, 32'h1);
    step(5);
    check("bounce_single_change", chg_cnt[4], 32'd1);
    check("bounce_rise_count", rise_cnt[4], EDGE ? 32'd1 : 32'd0);
    check("bounce_gpio", gpio_in_o, 32'h0000001E);

    // 4. Glitch on SW9 shorter than the qualification window.
    clear_counts();
    raw_i[13] = 1'b1; step(25);
    raw_i[13] = 1'b0; step(60);
    rsum = 0;
    for (int i = 0; i < NI; i++) rsum += rise_cnt[i];
    check("glitch_no_change", chg_cnt[13], 32'd0);
    check("glitch_no_rise", rsum, 32'd0);
    check("glitch_gpio", gpio_in_o, 32'h0000001E);

    // 5. Reset in the middle of KEY1 qualification.
    reset = 1'b1; raw_i = RV; step(3);
    reset = 1'b0; step(5);
    clear_counts();
    raw_i[1] = 1'b0; step(20);
    reset = 1'b1; step(3);
    check("midq_reset_gpio", gpio_in_o, 32'h0000000F);
    reset = 1'b0;
    wait_bit(1, 1'b0, 60, lat);
    check("midq_latency_ok", {31'b0, (lat >= 33 && lat <= 43)}, 32'h1);
    check("midq_latency_exact", lat, 32'd40);
    step(3);
    check("midq_fall_count", fall_cnt[1], EDGE ? 32'd1 : 32'd0);
    check("midq_gpio", gpio_in_o, 32'h0000000D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gpio_input_conditioner
`default_nettype wire
